// File: rtl/sound_dma_channel.sv
// Single-channel sound DMA engine: moves one byte/word per request between memory and
// the sound block, with a CPU-visible register file, autoinit and terminal-count reporting.
module sound_dma_channel #(
  parameter bit WIDE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  io_address,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [7:0]  io_writedata,
  output logic [7:0]  io_readdata,
  input  logic        dma_req,
  output logic        dma_ack,
  output logic [15:0] dma_readdata,
  input  logic [15:0] dma_writedata,
  output logic [23:0] mem_address,
  output logic [1:0]  mem_byteenable,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_writedata,
  input  logic [15:0] mem_readdata,
  input  logic        mem_waitrequest,
  input  logic        mem_readdatavalid,
  output logic        tc
);

  localparam int unsigned AW = 24;
  localparam int unsigned CW = 16;
  localparam int unsigned DW = 16;
  localparam logic [AW-1:0] ADDR_STEP = WIDE ? AW'(2) : AW'(1);

  typedef enum logic [2:0] {IDLE, MEM_RD, WAIT_DATA, ACK, MEM_WR, UPDATE} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  base_addr_q, base_addr_d, cur_addr_q, cur_addr_d;
  logic [CW-1:0]  base_cnt_q, base_cnt_d, cur_cnt_q, cur_cnt_d;
  logic           dir_q, dir_d, autoinit_q, autoinit_d, mask_q, mask_d;
  logic           tc_flag_q, tc_flag_d, tc_q, tc_d, tc_set;
  logic           dma_ack_q, dma_ack_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [DW-1:0]  mem_wdata_q, mem_wdata_d, dma_rdata_q, dma_rdata_d;
  logic [7:0]     io_rdata_q, io_rdata_d;

  // State and register file
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_addr_q <= '0;
      cur_addr_q  <= '0;
      base_cnt_q  <= '0;
      cur_cnt_q   <= '0;
      dir_q       <= 1'b0;
      autoinit_q  <= 1'b0;
      mask_q      <= 1'b1;
      tc_flag_q   <= 1'b0;
      tc_q        <= 1'b0;
      dma_ack_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= '0;
      dma_rdata_q <= '0;
      io_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_addr_q <= base_addr_d;
      cur_addr_q  <= cur_addr_d;
      base_cnt_q  <= base_cnt_d;
      cur_cnt_q   <= cur_cnt_d;
      dir_q       <= dir_d;
      autoinit_q  <= autoinit_d;
      mask_q      <= mask_d;
      tc_flag_q   <= tc_flag_d;
      tc_q        <= tc_d;
      dma_ack_q   <= dma_ack_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_wdata_q <= mem_wdata_d;
      dma_rdata_q <= dma_rdata_d;
      io_rdata_q  <= io_rdata_d;
    end
  end

  // Next-state: CPU writes first, then the FSM, so UPDATE owns the current copies
  always_comb begin
    state_d     = state_q;
    base_addr_d = base_addr_q;
    cur_addr_d  = cur_addr_q;
    base_cnt_d  = base_cnt_q;
    cur_cnt_d   = cur_cnt_q;
    dir_d       = dir_q;
    autoinit_d  = autoinit_q;
    mask_d      = mask_q;
    tc_flag_d   = tc_flag_q;
    tc_set      = 1'b0;
    mem_wdata_d = mem_wdata_q;
    dma_rdata_d = dma_rdata_q;
    io_rdata_d  = io_rdata_q;

    if (io_write) begin
      case (io_address)
        3'd0: begin base_addr_d[7:0]   = io_writedata; cur_addr_d[7:0]   = io_writedata; end
        3'd1: begin base_addr_d[15:8]  = io_writedata; cur_addr_d[15:8]  = io_writedata; end
        3'd2: begin base_addr_d[23:16] = io_writedata; cur_addr_d[23:16] = io_writedata; end
        3'd3: begin base_cnt_d[7:0]    = io_writedata; cur_cnt_d[7:0]    = io_writedata; end
        3'd4: begin base_cnt_d[15:8]   = io_writedata; cur_cnt_d[15:8]   = io_writedata; end
        3'd5: begin
          dir_d      = io_writedata[0];
          autoinit_d = io_writedata[1];
          mask_d     = io_writedata[2];
        end
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (dma_req && !mask_q) state_d = dir_q ? ACK : MEM_RD;
      end
      MEM_RD: begin
        if (!mem_waitrequest) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (mem_readdatavalid) begin
          dma_rdata_d = WIDE ? mem_readdata
                             : {8'h00, cur_addr_q[0] ? mem_readdata[15:8] : mem_readdata[7:0]};
          state_d     = ACK;
        end
      end
      ACK: begin
        if (dir_q) begin
          mem_wdata_d = WIDE ? dma_writedata : {2{dma_writedata[7:0]}};
          state_d     = MEM_WR;
        end else begin
          state_d = UPDATE;
        end
      end
      MEM_WR: begin
        if (!mem_waitrequest) state_d = UPDATE;
      end
      UPDATE: begin
        cur_addr_d = cur_addr_q + ADDR_STEP;
        cur_cnt_d  = cur_cnt_q - CW'(1);
        if (cur_cnt_q == '0) begin
          tc_set = 1'b1;
          if (autoinit_q) begin
            cur_addr_d = base_addr_q;
            cur_cnt_d  = base_cnt_q;
          end else begin
            mask_d = 1'b1;
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A terminal count landing on the same edge as a status read keeps the flag set
    if (tc_set) tc_flag_d = 1'b1;
    else if (io_read && io_address == 3'd6) tc_flag_d = 1'b0;

    // Status reports the post-edge view so a coincident terminal count is not lost
    if (io_read) begin
      case (io_address)
        3'd0:    io_rdata_d = cur_addr_q[7:0];
        3'd1:    io_rdata_d = cur_addr_q[15:8];
        3'd2:    io_rdata_d = cur_addr_q[23:16];
        3'd3:    io_rdata_d = cur_cnt_q[7:0];
        3'd4:    io_rdata_d = cur_cnt_q[15:8];
        3'd5:    io_rdata_d = {5'b0, mask_q, autoinit_q, dir_q};
        3'd6:    io_rdata_d = {5'b0, state_d != IDLE, mask_d, tc_flag_q | tc_set};
        default: io_rdata_d = 8'h00;
      endcase
    end

    tc_d        = tc_set;
    dma_ack_d   = (state_d == ACK);
    mem_read_d  = (state_d == MEM_RD);
    mem_write_d = (state_d == MEM_WR);
  end

  assign io_readdata    = io_rdata_q;
  assign dma_ack        = dma_ack_q;
  assign dma_readdata   = dma_rdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_writedata  = mem_wdata_q;
  assign tc             = tc_q;
  assign mem_address    = WIDE ? {cur_addr_q[AW-1:1], 1'b0} : cur_addr_q;
  assign mem_byteenable = WIDE ? 2'b11 : (cur_addr_q[0] ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_sound_dma_channel.sv
// Directed bench for sound_dma_channel: a word-wide instance for memory reads and a
// byte-wide instance for device-to-memory writes, sharing the CPU and memory inputs.
module tb_sound_dma_channel;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  io_address = '0;
  logic        io_read = 1'b0, io_write = 1'b0;
  logic [7:0]  io_writedata = '0;
  logic        dma_req = 1'b0, dma_req8 = 1'b0;
  logic [15:0] dma_writedata = '0;
  logic [15:0] mem_readdata;
  logic        mem_waitrequest = 1'b0;
  logic        mem_readdatavalid;
  logic        resp_en = 1'b1, rdv_auto = 1'b0, rdv_man = 1'b0;
  logic [15:0] rdata_q = '0;

  logic [7:0]  io_readdata, n_io_readdata;
  logic        dma_ack, n_dma_ack, mem_read, n_mem_read, mem_write, n_mem_write, tc, n_tc;
  logic [15:0] dma_readdata, n_dma_readdata, mem_writedata, n_mem_writedata;
  logic [23:0] mem_address, n_mem_address;
  logic [1:0]  mem_byteenable, n_mem_byteenable;

  int n_checks = 0;
  int n_err = 0;
  int ack_cnt = 0;

  always #5 clk = ~clk;

  sound_dma_channel #(.WIDE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .io_address(io_address), .io_read(io_read),
    .io_write(io_write), .io_writedata(io_writedata), .io_readdata(io_readdata),
    .dma_req(dma_req), .dma_ack(dma_ack), .dma_readdata(dma_readdata),
    .dma_writedata(dma_writedata), .mem_address(mem_address),
    .mem_byteenable(mem_byteenable), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest), .mem_readdatavalid(mem_readdatavalid), .tc(tc)
  );

  sound_dma_channel #(.WIDE(1'b0)) dut8 (
    .clk(clk), .rst_n(rst_n), .io_address(io_address), .io_read(io_read),
    .io_write(io_write), .io_writedata(io_writedata), .io_readdata(n_io_readdata),
    .dma_req(dma_req8), .dma_ack(n_dma_ack), .dma_readdata(n_dma_readdata),
    .dma_writedata(dma_writedata), .mem_address(n_mem_address),
    .mem_byteenable(n_mem_byteenable), .mem_read(n_mem_read), .mem_write(n_mem_write),
    .mem_writedata(n_mem_writedata), .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest), .mem_readdatavalid(mem_readdatavalid), .tc(n_tc)
  );

  // Memory returns address ^ 0xA5A5 the cycle after a read is accepted
  always @(posedge clk) begin
    rdv_auto <= mem_read && !mem_waitrequest;
    rdata_q  <= mem_address[15:0] ^ 16'hA5A5;
    if (dma_ack) ack_cnt <= ack_cnt + 1;
  end
  assign mem_readdatavalid = resp_en ? rdv_auto : rdv_man;
  assign mem_readdata      = rdata_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk); io_address = a; io_writedata = d; io_write = 1'b1;
    @(negedge clk); io_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d, output logic [7:0] nd);
    @(negedge clk); io_address = a; io_read = 1'b1;
    @(negedge clk); io_read = 1'b0; d = io_readdata; nd = n_io_readdata;
  endtask

  task automatic xfer_rd(input logic [23:0] a, input logic [15:0] d, input int waits,
                         input bit rd_upd, output logic tc_seen, output logic [7:0] stat);
    int nrd;
    int ack0;
    @(negedge clk); dma_req = 1'b1; mem_waitrequest = (waits > 0);
    @(negedge clk); dma_req = 1'b0;
    chk("mem_read_start", 32'(mem_read), 32'd1);
    chk("mem_address", 32'(mem_address), 32'(a));
    chk("byteenable", 32'(mem_byteenable), 32'd3);
    nrd  = 1;
    ack0 = ack_cnt;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      if (mem_read) nrd++;
      if (i == waits - 1) mem_waitrequest = 1'b0;
    end
    @(negedge clk); chk("mem_read_drop", 32'(mem_read), 32'd0);
    @(negedge clk);
    chk("dma_ack", 32'(dma_ack), 32'd1);
    chk("dma_readdata", 32'(dma_readdata), 32'(d));
    @(negedge clk); chk("dma_ack_one_cycle", 32'(dma_ack), 32'd0);
    if (rd_upd) begin io_address = 3'd6; io_read = 1'b1; end
    @(negedge clk); io_read = 1'b0;
    tc_seen = tc;
    stat    = io_readdata;
    chk("mem_read_cycles", 32'(nrd), 32'(waits + 1));
    chk("single_ack", 32'(ack_cnt), 32'(ack0 + 1));
  endtask

  initial begin
    logic [7:0] r, nr;
    logic       tcs;
    int         ack0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_io_readdata", 32'(io_readdata), 32'd0);
    chk("rst_dma_ack", 32'(dma_ack), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_tc", 32'(tc), 32'd0);
    chk("rst_dma_readdata", 32'(dma_readdata), 32'd0);
    chk("rst_n_io_readdata", 32'(n_io_readdata), 32'd0);
    rst_n = 1'b1;
    rd(3'd6, r, nr); chk("rst_status", 32'(r), 32'h02);
    rd(3'd0, r, nr); chk("rst_addr0", 32'(r), 32'h00);

    // Two word reads from 0x012340, count 1
    wr(3'd0, 8'h40); wr(3'd1, 8'h23); wr(3'd2, 8'h01);
    wr(3'd3, 8'h01); wr(3'd4, 8'h00); wr(3'd5, 8'h00);
    rd(3'd1, r, nr); chk("addr1_readback", 32'(r), 32'h23);
    xfer_rd(24'h012340, 16'h86E5, 0, 1'b0, tcs, r); chk("tc_first", 32'(tcs), 32'd0);
    rd(3'd0, r, nr); chk("cur_addr0_step", 32'(r), 32'h42);
    rd(3'd3, r, nr); chk("cur_cnt0_dec", 32'(r), 32'h00);
    xfer_rd(24'h012342, 16'h86E7, 0, 1'b0, tcs, r); chk("tc_second", 32'(tcs), 32'd1);
    @(negedge clk); chk("tc_pulse_end", 32'(tc), 32'd0);
    rd(3'd6, r, nr); chk("status_tc_mask", 32'(r), 32'h03);
    rd(3'd6, r, nr); chk("status_cleared", 32'(r), 32'h02);

    // Autoinit, count 0: every transfer at base address with terminal count
    wr(3'd0, 8'h00); wr(3'd1, 8'h02); wr(3'd2, 8'h00);
    wr(3'd3, 8'h00); wr(3'd4, 8'h00); wr(3'd5, 8'h02);
    for (int k = 0; k < 3; k++) begin
      xfer_rd(24'h000200, 16'hA7A5, 0, 1'b0, tcs, r); chk("tc_autoinit", 32'(tcs), 32'd1);
    end
    rd(3'd5, r, nr); chk("mode_mask_clear", 32'(r), 32'h02);

    // Four wait states on the read
    xfer_rd(24'h000200, 16'hA7A5, 4, 1'b0, tcs, r); chk("tc_wait", 32'(tcs), 32'd1);
    rd(3'd6, r, nr); chk("status_autoinit", 32'(r), 32'h01);
    rd(3'd6, r, nr); chk("status_autoinit_clr", 32'(r), 32'h00);

    // Status read on the same edge the terminal count lands
    wr(3'd1, 8'h03); wr(3'd3, 8'h00); wr(3'd5, 8'h00);
    xfer_rd(24'h000300, 16'hA6A5, 0, 1'b1, tcs, r);
    chk("tc_coincident", 32'(tcs), 32'd1);
    chk("status_coincident", 32'(r), 32'h03);
    rd(3'd6, r, nr); chk("status_flag_kept", 32'(r), 32'h03);
    rd(3'd6, r, nr); chk("status_flag_clr", 32'(r), 32'h02);

    // Byte-wide device-to-memory write at odd address
    wr(3'd0, 8'h01); wr(3'd1, 8'h01); wr(3'd2, 8'h00);
    wr(3'd3, 8'h00); wr(3'd4, 8'h00); wr(3'd5, 8'h01);
    dma_writedata = 16'h00A5; mem_waitrequest = 1'b0;
    @(negedge clk); dma_req8 = 1'b1;
    @(negedge clk); dma_req8 = 1'b0; chk("n_dma_ack", 32'(n_dma_ack), 32'd1);
    @(negedge clk);
    chk("n_mem_write", 32'(n_mem_write), 32'd1);
    chk("n_mem_address", 32'(n_mem_address), 32'h000101);
    chk("n_byteenable", 32'(n_mem_byteenable), 32'h2);
    chk("n_mem_writedata", 32'(n_mem_writedata), 32'hA5A5);
    @(negedge clk); chk("n_mem_write_drop", 32'(n_mem_write), 32'd0);
    @(negedge clk); chk("n_tc", 32'(n_tc), 32'd1);
    rd(3'd0, r, nr); chk("n_addr_step", 32'(nr), 32'h02);
    rd(3'd6, r, nr); chk("n_status", 32'(nr), 32'h03);

    // Masked channel ignores requests
    wr(3'd5, 8'h04);
    ack0 = ack_cnt;
    @(negedge clk); dma_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("masked_no_read", 32'(mem_read), 32'd0);
    dma_req = 1'b0;
    @(negedge clk); chk("masked_no_ack", 32'(ack_cnt), 32'(ack0));

    // Reset while waiting for read data, then a late readdatavalid
    wr(3'd5, 8'h00); wr(3'd0, 8'h00); wr(3'd1, 8'h05); wr(3'd3, 8'h03);
    resp_en = 1'b0;
    ack0 = ack_cnt;
    @(negedge clk); dma_req = 1'b1; mem_waitrequest = 1'b0;
    @(negedge clk); dma_req = 1'b0; chk("rst_mid_read", 32'(mem_read), 32'd1);
    @(negedge clk); chk("rst_mid_wait", 32'(mem_read), 32'd0); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; rdv_man = 1'b1;
    @(negedge clk); rdv_man = 1'b0;
    chk("late_rdv_no_ack", 32'(dma_ack), 32'd0);
    chk("late_rdv_no_read", 32'(mem_read), 32'd0);
    @(negedge clk); chk("late_rdv_ack_cnt", 32'(ack_cnt), 32'(ack0));
    rd(3'd6, r, nr); chk("rst2_status", 32'(r), 32'h02);
    rd(3'd1, r, nr); chk("rst2_addr1", 32'(r), 32'h00);
    rd(3'd3, r, nr); chk("rst2_cnt0", 32'(r), 32'h00);
    rd(3'd5, r, nr); chk("rst2_mode", 32'(r), 32'h04);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/sound_dma_channel.md
SOUND_DMA_CHANNEL -- requirements
Module: sound_dma_channel

Interface
REQ-001 Parameter WIDE, default 1: 1 = 16-bit word transfers; 0 = 8-bit byte transfers.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 io_address  input  3  register select.
REQ-005 io_read / io_write  input  1 each  register read / write strobes, one cycle each.
REQ-006 io_writedata  input  8  register write data; io_readdata  output  8  registered read data.
REQ-007 dma_req  input  1  transfer request from sound block.
REQ-008 dma_ack  output  1  one-cycle transfer acknowledge.
REQ-009 dma_readdata  output  16  memory-to-device data; dma_writedata  input  16  device-to-memory data.
REQ-010 mem_address  output  24  byte address; mem_byteenable  output  2  lane enables.
REQ-011 mem_read / mem_write  output  1 each  memory master strobes; mem_writedata  output  16.
REQ-012 mem_readdata  input  16; mem_waitrequest  input  1; mem_readdatavalid  input  1.
REQ-013 tc  output  1  one-cycle terminal-count pulse.

Function
REQ-014 Registers: 0 addr[7:0], 1 addr[15:8], 2 addr[23:16], 3 count[7:0], 4 count[15:8], 5 mode {bit0 dir (0 mem->dev, 1 dev->mem), bit1 autoinit, bit2 mask}, 6 status {bit0 tc_flag, bit1 mask, bit2 busy}, 7 reads 0x00.
REQ-015 Writes to 0-4 load both base and current copies; count value N yields N+1 transfers.
REQ-016 io_readdata valid cycle after io_read; 0-4 return current copies.
REQ-017 Status read clears tc_flag; tc set in same cycle as the read takes priority (flag stays 1).
REQ-018 FSM states: IDLE, MEM_RD, WAIT_DATA, ACK, MEM_WR, UPDATE.
REQ-019 IDLE: dma_req=1 and mask=0 -> MEM_RD if dir=0, else ACK; dma_req sampled only in IDLE.
REQ-020 MEM_RD: mem_read=1 held until mem_waitrequest=0, then WAIT_DATA.
REQ-021 WAIT_DATA: on mem_readdatavalid latch lane data into dma_readdata, go ACK.
REQ-022 ACK: dma_ack=1 exactly one cycle; dir=1 captures dma_writedata, goes MEM_WR; dir=0 goes UPDATE.
REQ-023 MEM_WR: mem_write=1 held until mem_waitrequest=0, then UPDATE.
REQ-024 UPDATE: address += 2 (WIDE=1) or 1 (WIDE=0), 24-bit wrap; count -= 1, 16-bit wrap; return IDLE.
REQ-025 UPDATE with count==0 before decrement: tc=1, tc_flag=1; autoinit=1 reloads current from base, else mask set to 1.
REQ-026 dma_req dropping after leaving IDLE does not abort the transfer.
REQ-027 Minimum dir=0 latency, zero wait, readdatavalid next cycle: req sampled edge T, mem_read at T+1, dma_ack at T+3.
REQ-028 WIDE=1: mem_address[0]=0, byteenable 2'b11, full 16-bit data.
REQ-029 WIDE=0: byteenable 2'b01 if address[0]=0 else 2'b10; write data replicated both lanes; read lane selected by address[0] into dma_readdata[7:0], [15:8]=0.
REQ-030 io write to address/count in UPDATE cycle: UPDATE wins for current copy, base takes write.
REQ-031 Mask write takes effect next cycle; an in-progress transfer completes.

Reset
REQ-032 rst_n=0: FSM IDLE, all registers 0 except mask=1, dma_ack/mem_read/mem_write/tc=0, io_readdata=0, dma_readdata=0.
REQ-033 Reset mid-transfer drops strobes next edge; late mem_readdatavalid after reset is ignored.

Verification
REQ-034 WIDE=1, addr 0x012340, count 0x0001, mode 0x00, two reqs, zero wait -> reads at 0x012340, 0x012342, dma_ack at T+3, tc pulse on second UPDATE, mask=1.
REQ-035 Autoinit mode 0x02, count 0x0000, three reqs -> all at base address, tc each transfer, mask stays 0.
REQ-036 dir=1 WIDE=0, addr 0x000101, dma_writedata 0x00A5 -> mem_write 0x0101, byteenable 2'b10, mem_writedata 0xA5A5.
REQ-037 mem_waitrequest high 4 cycles in MEM_RD -> mem_read held 5 cycles, single dma_ack.
REQ-038 Status read in tc cycle -> returns 0x02 or 0x03 per timing, tc_flag still 1 afterward; next read clears.
REQ-039 rst_n low in WAIT_DATA then readdatavalid -> no dma_ack, registers reset, mask=1.
